// File: rtl/jk_counter_pkg.sv
// Shared mode encodings for the JK-based counter and its testbench.
package jk_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-low reset to 0.
module jk_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_counter.sv
// Modulus counter built from WIDTH JK cells: hold/up/down/load with wrap at MAX_COUNT.
module jk_counter
    import jk_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_COUNT = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_COUNT);

    mode_t            mode_sel;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    assign mode_sel = mode_t'(mode);

    // Out-of-range states (q > MAX) fall into the wrap branches: up -> 0, down -> MAX.
    always_comb begin
        nxt = q;
        if (en) begin
            case (mode_sel)
                MODE_UP:   nxt = (q >= MAX) ? '0 : q + WIDTH'(1);
                MODE_DOWN: nxt = ((q == '0) || (q > MAX)) ? MAX : q - WIDTH'(1);
                MODE_LOAD: nxt = (load_val > MAX) ? MAX : load_val;
                default:   nxt = q;
            endcase
        end
    end

    // Drive only the bits that change; J=K=1 can never occur.
    assign j = nxt & ~q;
    assign k = ~nxt & q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (j[i]),
            .k     (k[i]),
            .q     (q[i])
        );
    end

    assign tc = en & (((mode_sel == MODE_UP) & (q == MAX)) |
                      ((mode_sel == MODE_DOWN) & (q == '0)));

endmodule
